// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: widths, opcode map, fetch FSM states.
// Latency: none (package only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] word_t;

  // 4-bit major opcode carried in instr[15:12]
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LUI  = 4'h8,
    OP_LW   = 4'h9,
    OP_SW   = 4'hA,
    OP_JAL  = 4'hB,
    OP_BR   = 4'hC,
    OP_JR   = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Fetch-stage FSM encoding
  typedef enum logic {
    IF_RUN    = 1'b0,
    IF_HALTED = 1'b1
  } if_state_e;

  function automatic opcode_e get_opcode(input word_t instr);
    return opcode_e'(instr[15:12]);
  endfunction

  // Sign-extend an 8-bit branch offset to the machine width
  function automatic word_t sext8(input logic [7:0] imm);
    return {{(XLEN-8){imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of fetch-stage signals: instruction memory port, hazard/redirect controls, IF/ID register outputs.
// Latency: none (wiring only).
// Backpressure: stall from the hazard unit holds the fetch stage; there is no ready signal.
interface if_stage_if;
  import cpu_pkg::*;

  word_t imem_addr;
  word_t imem_data;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t ifid_instr;
  word_t ifid_pc1;
  logic  ifid_valid;
  logic  ifid_pred_taken;
  logic  halted;

  // Fetch stage side
  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output ifid_instr,
    output ifid_pc1,
    output ifid_valid,
    output ifid_pred_taken,
    output halted
  );

  // Memory / hazard / decode side
  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output redirect,
    output redirect_pc,
    input  ifid_instr,
    input  ifid_pc1,
    input  ifid_valid,
    input  ifid_pred_taken,
    input  halted
  );

endinterface

// File: rtl/if_next_pc.sv
// Combinational next-PC generator: PC+1, branch target, static backward-taken prediction, HALT decode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; config macro IF_BTFN_PREDICT_EN enables backward-taken prediction.
module if_next_pc
  import cpu_pkg::*;
(
  input  word_t pc,
  input  word_t instr,
  output word_t pc1,
  output word_t target,
  output logic  pred_taken,
  output logic  is_halt
);

  opcode_e opcode;
  logic    unused_mid;

  assign opcode  = get_opcode(instr);
  assign pc1     = pc + word_t'(1);
  // Target is relative to the following instruction, matching execute's resolution
  assign target  = pc1 + sext8(instr[7:0]);
  assign is_halt = (opcode == OP_HALT);

`ifdef IF_BTFN_PREDICT_EN
  // Backward conditional branches are usually loop closers: predict them taken
  assign pred_taken = (opcode == OP_BR) && instr[7];
`else
  assign pred_taken = 1'b0;
`endif

  // Register-field bits have no meaning to fetch
  assign unused_mid = ^instr[11:8];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns PC, drives imem address, captures word + PC+1 + valid into IF/ID; stops on HALT.
// Latency: 1 cycle from PC presented to ifid_* valid; redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall and HALTED. Macro: IF_BTFN_PREDICT_EN.
module if_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
)
(
  input  logic       Clk,
  input  logic       Rst,
  if_stage_if.master fetch
);

  word_t     pc;
  if_state_e state;
  word_t     ifid_instr_q;
  word_t     ifid_pc1_q;
  logic      ifid_valid_q;
  logic      ifid_pred_taken_q;

  word_t     pc1;
  word_t     target;
  word_t     next_pc;
  logic      pred_taken;
  logic      is_halt;

  if_next_pc u_next_pc (
    .pc         (pc),
    .instr      (fetch.imem_data),
    .pc1        (pc1),
    .target     (target),
    .pred_taken (pred_taken),
    .is_halt    (is_halt)
  );

  assign next_pc = pred_taken ? target : pc1;

  // Fetch FSM, PC and IF/ID register; priority Rst > redirect > stall > state action
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc                <= RESET_PC;
      state             <= IF_RUN;
      ifid_instr_q      <= '0;
      ifid_pc1_q        <= '0;
      ifid_valid_q      <= 1'b0;
      ifid_pred_taken_q <= 1'b0;
    end else if (fetch.redirect) begin
      // Instruction/pc1 fields keep their stale contents; valid=0 marks the bubble
      pc                <= fetch.redirect_pc;
      state             <= IF_RUN;
      ifid_valid_q      <= 1'b0;
      ifid_pred_taken_q <= 1'b0;
    end else if (!fetch.stall) begin
      case (state)
        IF_RUN: begin
          ifid_instr_q      <= fetch.imem_data;
          ifid_pc1_q        <= pc1;
          ifid_valid_q      <= 1'b1;
          if (is_halt) begin
            ifid_pred_taken_q <= 1'b0;
            pc                <= pc1;
            state             <= IF_HALTED;
          end else begin
            ifid_pred_taken_q <= pred_taken;
            pc                <= next_pc;
          end
        end
        IF_HALTED: begin
          ifid_valid_q      <= 1'b0;
          ifid_pred_taken_q <= 1'b0;
        end
        default: begin
          state <= IF_RUN;
        end
      endcase
    end
  end

  assign fetch.imem_addr       = pc;
  assign fetch.ifid_instr      = ifid_instr_q;
  assign fetch.ifid_pc1        = ifid_pc1_q;
  assign fetch.ifid_valid      = ifid_valid_q;
  assign fetch.ifid_pred_taken = ifid_pred_taken_q;
  assign fetch.halted          = (state == IF_HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, straight-line fetch, stall/redirect, HALT, PC wrap, prediction.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: stall and redirect driven on the falling edge.
module tb_if_stage;

  logic Clk;
  logic Rst;
  int   n_total;
  int   n_pass;

  logic [15:0] mem [256];

  if_stage_if bus0 ();
  if_stage_if bus1 ();

  if_stage #(.RESET_PC(16'h0000)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .fetch (bus0)
  );

  if_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
    .Clk   (Clk),
    .Rst   (Rst),
    .fetch (bus1)
  );

  assign bus0.imem_data   = mem[bus0.imem_addr[7:0]];
  assign bus1.imem_data   = 16'h1000;
  assign bus1.stall       = 1'b0;
  assign bus1.redirect    = 1'b0;
  assign bus1.redirect_pc = 16'h0000;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_redirect(input logic [15:0] target);
    bus0.redirect    = 1'b1;
    bus0.redirect_pc = target;
    tick();
    bus0.redirect    = 1'b0;
  endtask

`ifdef IF_BTFN_PREDICT_EN
  localparam logic [15:0] EXP_PRED = 16'h0001;
  localparam logic [15:0] EXP_NPC  = 16'h001F;
`else
  localparam logic [15:0] EXP_PRED = 16'h0000;
  localparam logic [15:0] EXP_NPC  = 16'h0021;
`endif

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
    mem[7]    = 16'hF000;
    mem[8'h20] = 16'hC0FE;

    Rst              = 1'b1;
    bus0.stall       = 1'b0;
    bus0.redirect    = 1'b0;
    bus0.redirect_pc = 16'h0000;

    // Reset for two cycles
    tick();
    tick();
    check("rst_addr",   bus0.imem_addr,             16'h0000);
    check("rst_instr",  bus0.ifid_instr,            16'h0000);
    check("rst_pc1",    bus0.ifid_pc1,              16'h0000);
    check("rst_valid",  {15'd0, bus0.ifid_valid},   16'h0000);
    check("rst_pred",   {15'd0, bus0.ifid_pred_taken}, 16'h0000);
    check("rst_halted", {15'd0, bus0.halted},       16'h0000);
    check("wrap_rst_addr", bus1.imem_addr,          16'hFFFF);
    Rst = 1'b0;

    // Straight-line fetch from 0
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("run_pc1",   bus0.ifid_pc1,            16'(i));
      check("run_valid", {15'd0, bus0.ifid_valid}, 16'h0001);
      if (i == 1) begin
        check("wrap_pc1",  bus1.ifid_pc1,  16'h0000);
        check("wrap_addr", bus1.imem_addr, 16'h0000);
      end
    end
    check("run_instr", bus0.ifid_instr, 16'h1000);
    tick();
    check("pc_at_5", bus0.imem_addr, 16'h0005);

    // Stall three cycles at PC=5
    bus0.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr",  bus0.imem_addr,            16'h0005);
      check("stall_pc1",   bus0.ifid_pc1,             16'h0005);
      check("stall_valid", {15'd0, bus0.ifid_valid},  16'h0001);
    end

    // Redirect wins over stall
    do_redirect(16'h0040);
    check("redir_valid", {15'd0, bus0.ifid_valid}, 16'h0000);
    check("redir_addr",  bus0.imem_addr,           16'h0040);
    bus0.stall = 1'b0;
    tick();
    check("redir_pc1",   bus0.ifid_pc1,            16'h0041);
    check("redir_valid2", {15'd0, bus0.ifid_valid}, 16'h0001);

    // HALT at address 7
    do_redirect(16'h0007);
    tick();
    check("halt_instr",  bus0.ifid_instr,           16'hF000);
    check("halt_valid",  {15'd0, bus0.ifid_valid},  16'h0001);
    check("halt_flag",   {15'd0, bus0.halted},      16'h0001);
    check("halt_addr",   bus0.imem_addr,            16'h0008);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halted_addr",  bus0.imem_addr,           16'h0008);
      check("halted_valid", {15'd0, bus0.ifid_valid}, 16'h0000);
      check("halted_flag",  {15'd0, bus0.halted},     16'h0001);
    end
    do_redirect(16'h0010);
    check("unhalt_flag", {15'd0, bus0.halted},     16'h0000);
    check("unhalt_addr", bus0.imem_addr,           16'h0010);
    tick();
    check("resume_pc1",   bus0.ifid_pc1,            16'h0011);
    check("resume_valid", {15'd0, bus0.ifid_valid}, 16'h0001);

    // Backward branch at 0x20
    do_redirect(16'h0020);
    tick();
    check("bwd_instr", bus0.ifid_instr,                  16'hC0FE);
    check("bwd_pred",  {15'd0, bus0.ifid_pred_taken},    EXP_PRED);
    check("bwd_npc",   bus0.imem_addr,                   EXP_NPC);

    // Forward branch at 0x20 is never predicted
    mem[8'h20] = 16'hC005;
    do_redirect(16'h0020);
    tick();
    check("fwd_instr", bus0.ifid_instr,               16'hC005);
    check("fwd_pred",  {15'd0, bus0.ifid_pred_taken}, 16'h0000);
    check("fwd_npc",   bus0.imem_addr,                16'h0021);

    // Reset taken while halted
    mem[8'h21] = 16'hF000;
    tick();
    check("halt2_flag", {15'd0, bus0.halted}, 16'h0001);
    Rst = 1'b1;
    tick();
    check("rst_halt_flag", {15'd0, bus0.halted},     16'h0000);
    check("rst_halt_addr", bus0.imem_addr,           16'h0000);
    check("rst_halt_pc1",  bus0.ifid_pc1,            16'h0000);
    Rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
